// File: rtl/button_event_parser.sv
// Multi-channel button front end: synchronise, debounce press/release, and emit
// press / release / long-press pulses. Optional auto-repeat: BUTTON_AUTOREPEAT_EN.
module button_event_parser #(
  parameter int WIDTH          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int SAMPLE_CNT_MAX = 37500,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int LONG_CNT_MAX   = 2000,
  parameter int REPEAT_CNT_MAX = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] released,
  output logic [WIDTH-1:0] long_press
);

  localparam int SAMPLE_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_CNT_MAX - 1);

  localparam int CNT_MAX_PL = (PULSE_CNT_MAX > LONG_CNT_MAX) ? PULSE_CNT_MAX : LONG_CNT_MAX;
  localparam int CNT_MAX    = (CNT_MAX_PL > REPEAT_CNT_MAX) ? CNT_MAX_PL : REPEAT_CNT_MAX;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_CNT_MAX - 1);
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT_MAX - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_REL_DB
  } state_t;

  // Shared sample timebase; tick qualifies every per-channel state update.
  logic [SAMPLE_W-1:0] sample_cnt_reg;
  logic                tick;

  assign tick = (sample_cnt_reg == SAMPLE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_reg <= '0;
    end else if (tick) begin
      sample_cnt_reg <= '0;
    end else begin
      sample_cnt_reg <= sample_cnt_reg + SAMPLE_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   s;
      state_t                 state_reg;
      logic [CNT_W-1:0]       cnt_reg;
      logic                   long_done_reg;
      logic                   level_reg;
      logic                   pressed_reg;
      logic                   released_reg;
      logic                   long_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], in[gi]};
        end
      end

      assign s = sync_reg[SYNC_STAGES-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg     <= ST_IDLE;
          cnt_reg       <= CNT_ZERO;
          long_done_reg <= 1'b0;
          level_reg     <= 1'b0;
          pressed_reg   <= 1'b0;
          released_reg  <= 1'b0;
          long_reg      <= 1'b0;
        end else begin
          pressed_reg  <= 1'b0;
          released_reg <= 1'b0;
          long_reg     <= 1'b0;
          if (tick) begin
            case (state_reg)
              ST_IDLE: begin
                if (s) begin
                  if (cnt_reg == PULSE_LAST) begin
                    state_reg     <= ST_HELD;
                    cnt_reg       <= CNT_ZERO;
                    long_done_reg <= 1'b0;
                    level_reg     <= 1'b1;
                    pressed_reg   <= 1'b1;
                  end else begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                  end
                end else begin
                  cnt_reg <= CNT_ZERO;
                end
              end

              ST_HELD: begin
                if (!s) begin
                  // A single-sample debounce has nothing left to confirm.
                  if (PULSE_CNT_MAX == 1) begin
                    state_reg    <= ST_IDLE;
                    cnt_reg      <= CNT_ZERO;
                    level_reg    <= 1'b0;
                    released_reg <= 1'b1;
                  end else begin
                    state_reg <= ST_REL_DB;
                    cnt_reg   <= CNT_ONE;
                  end
                end else if (!long_done_reg) begin
                  if (cnt_reg == LONG_LAST) begin
                    long_reg      <= 1'b1;
                    long_done_reg <= 1'b1;
                    cnt_reg       <= CNT_ZERO;
                  end else begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                  end
                end
`ifdef BUTTON_AUTOREPEAT_EN
                else begin
                  if (cnt_reg == REPEAT_LAST) begin
                    pressed_reg <= 1'b1;
                    cnt_reg     <= CNT_ZERO;
                  end else begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                  end
                end
`endif
              end

              ST_REL_DB: begin
                if (!s) begin
                  if (cnt_reg == PULSE_LAST) begin
                    state_reg    <= ST_IDLE;
                    cnt_reg      <= CNT_ZERO;
                    level_reg    <= 1'b0;
                    released_reg <= 1'b1;
                  end else begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                  end
                end else begin
                  // Glitch: long_done survives so one press yields one long_press.
                  state_reg <= ST_HELD;
                  cnt_reg   <= CNT_ZERO;
                end
              end

              default: begin
                state_reg <= ST_IDLE;
                cnt_reg   <= CNT_ZERO;
              end
            endcase
          end
        end
      end

      assign level[gi]      = level_reg;
      assign pressed[gi]    = pressed_reg;
      assign released[gi]   = released_reg;
      assign long_press[gi] = long_reg;
    end
  endgenerate

endmodule

// File: tb/tb_button_event_parser.sv
// Randomised and directed bench for button_event_parser, checked every cycle
// against a run-length model of the debounce rules.
module tb_button_event_parser;
  localparam int W   = 4;
  localparam int SS  = 2;
  localparam int SMP = 4;
  localparam int PUL = 3;
  localparam int LNG = 8;
  localparam int REP = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] btn = '0;
  logic [W-1:0] level, pressed, released, long_press;

  button_event_parser #(
    .WIDTH(W), .SYNC_STAGES(SS), .SAMPLE_CNT_MAX(SMP),
    .PULSE_CNT_MAX(PUL), .LONG_CNT_MAX(LNG), .REPEAT_CNT_MAX(REP)
  ) dut (
    .clk(clk), .rst(rst), .in(btn), .level(level), .pressed(pressed),
    .released(released), .long_press(long_press)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_le(input string name, input longint act, input longint bound);
    checks++;
    if (act > bound) begin
      errors++;
      $display("FAIL %s: got %0d, expected at most %0d (cycle %0d)", name, act, bound, cyc);
    end
  endtask

  // Reference model: sample-domain run lengths rather than a state machine.
  logic [W-1:0] dly [SS];
  logic [W-1:0] m_s;
  logic [W-1:0] exp_level, exp_pressed, exp_released, exp_long;
  int           hi_run [W];
  int           lo_run [W];
  int           anchor [W];
  int           rep_anchor [W];
  bit           long_done [W];
  longint       mcyc;

  task automatic model_reset();
    for (int k = 0; k < SS; k++) dly[k] = '0;
    exp_level = '0; exp_pressed = '0; exp_released = '0; exp_long = '0;
    for (int c = 0; c < W; c++) begin
      hi_run[c] = 0; lo_run[c] = 0; anchor[c] = 0; rep_anchor[c] = 0; long_done[c] = 0;
    end
    mcyc = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        m_s = dly[SS-1];
        for (int k = SS - 1; k > 0; k--) dly[k] = dly[k-1];
        dly[0] = btn;
        exp_pressed = '0; exp_released = '0; exp_long = '0;
        if (mcyc % SMP == SMP - 1) begin
          for (int c = 0; c < W; c++) begin
            if (m_s[c]) begin hi_run[c]++; lo_run[c] = 0; end
            else begin lo_run[c]++; hi_run[c] = 0; end
            if (!exp_level[c]) begin
              if (hi_run[c] == PUL) begin
                exp_level[c] = 1'b1; exp_pressed[c] = 1'b1;
                anchor[c] = hi_run[c]; long_done[c] = 0;
              end
            end else if (!m_s[c]) begin
              if (lo_run[c] == PUL) begin
                exp_level[c] = 1'b0; exp_released[c] = 1'b1;
              end
            end else begin
              if (hi_run[c] == 1) begin anchor[c] = 1; rep_anchor[c] = 1; end
              if (!long_done[c] && hi_run[c] - anchor[c] == LNG) begin
                exp_long[c] = 1'b1; long_done[c] = 1; rep_anchor[c] = hi_run[c];
              end
`ifdef BUTTON_AUTOREPEAT_EN
              else if (long_done[c] && hi_run[c] > rep_anchor[c] &&
                       (hi_run[c] - rep_anchor[c]) % REP == 0) begin
                exp_pressed[c] = 1'b1;
              end
`endif
            end
          end
        end
        mcyc++;
      end
    end
  end

  // Per-cycle comparison plus event bookkeeping for the directed checks.
  int     n_press [W];
  int     n_rel [W];
  int     n_long [W];
  longint last_press [W];
  longint last_rel [W];
  longint last_long [W];
  longint long_gap [W];
  bit     all_press_seen, all_rel_seen;

  initial begin
    for (int c = 0; c < W; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0;
      last_press[c] = 0; last_rel[c] = 0; last_long[c] = 0; long_gap[c] = 0;
    end
    all_press_seen = 0; all_rel_seen = 0;
    forever begin
      @(negedge clk);
      check_vec("level", level, exp_level);
      check_vec("pressed", pressed, exp_pressed);
      check_vec("released", released, exp_released);
      check_vec("long_press", long_press, exp_long);
      check_vec("pulse_exclusive", (pressed & released) | (pressed & long_press) | (released & long_press), '0);
      for (int c = 0; c < W; c++) begin
        if (pressed[c] === 1'b1) begin n_press[c]++; last_press[c] = cyc; end
        if (released[c] === 1'b1) begin n_rel[c]++; last_rel[c] = cyc; end
        if (long_press[c] === 1'b1) begin
          n_long[c]++; last_long[c] = cyc; long_gap[c] = cyc - last_press[c];
        end
      end
      if (pressed === 4'b1111) all_press_seen = 1;
      if (released === 4'b1111) all_rel_seen = 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int     p0, r0, l0, p1, p2, r2, pa;
  longint e;
  int     timer [W];

  initial begin
    rst = 1'b0;
    #2 rst = 1'b1;
    step(3);
    check_vec("reset_level", level, '0);
    check_vec("reset_pulses", pressed | released | long_press, '0);
    rst = 1'b0;
    step(4);

    // Clean press on channel 0
    p0 = n_press[0]; pa = n_press[1] + n_press[2] + n_press[3];
    btn[0] = 1'b1; e = cyc;
    step(16);
    check_int("clean_press_count", n_press[0] - p0, 1);
    check_le("clean_press_latency", last_press[0] - e, 16);
    check_int("clean_press_level", level[0], 1);
    check_int("clean_press_others", n_press[1] + n_press[2] + n_press[3] - pa, 0);

    // Bounce rejection on channel 1
    p1 = n_press[1];
    btn[1] = 1'b1; step(6); btn[1] = 1'b0; step(20);
    check_int("bounce_no_press", n_press[1] - p1, 0);
    check_int("bounce_level", level[1], 0);
    btn[1] = 1'b1; step(20);
    check_int("bounce_then_press", n_press[1] - p1, 1);
    btn[1] = 1'b0; step(20);

    // Long press and release on channel 2
    p2 = n_press[2]; l0 = n_long[2]; r2 = n_rel[2];
    btn[2] = 1'b1; step(56);
    check_int("long_count", n_long[2] - l0, 1);
    check_int("long_gap", long_gap[2], 32);
`ifdef BUTTON_AUTOREPEAT_EN
    check_int("repeat_phase", (last_press[2] - last_long[2]) % 8, 0);
    check_int("repeat_after_long", last_press[2] > last_long[2], 1);
`else
    check_int("long_single_press", n_press[2] - p2, 1);
`endif
    btn[2] = 1'b0; e = cyc;
    step(16);
    check_int("long_release_count", n_rel[2] - r2, 1);
    check_le("long_release_latency", last_rel[2] - e, 16);
    check_int("long_release_level", level[2], 0);

    // Release glitch on channel 0 (still held)
    p0 = n_press[0]; r0 = n_rel[0];
    btn[0] = 1'b0; step(5); btn[0] = 1'b1; step(20);
    check_int("glitch_no_release", n_rel[0] - r0, 0);
    check_int("glitch_level", level[0], 1);
`ifndef BUTTON_AUTOREPEAT_EN
    check_int("glitch_no_press", n_press[0] - p0, 0);
`endif
    btn[0] = 1'b0; step(20);

    // Simultaneous channels
    all_press_seen = 0; all_rel_seen = 0;
    btn = 4'b1111; step(16);
    check_int("simul_press", all_press_seen, 1);
    btn = 4'b0000; step(16);
    check_int("simul_release", all_rel_seen, 1);
    step(8);

    // Reset while channel 0 is debouncing its release
    btn[0] = 1'b1; step(16);
    btn[0] = 1'b0; step(6);
    r0 = n_rel[0];
    check_int("pre_reset_level", level[0], 1);
    #2 rst = 1'b1;
    #1;
    check_vec("async_reset_level", level, '0);
    check_vec("async_reset_pulses", pressed | released | long_press, '0);
    step(3);
    rst = 1'b0;
    step(20);
    check_int("reset_no_release", n_rel[0] - r0, 0);
    check_int("reset_level_low", level[0], 0);

    // Randomised traffic with one reset in the middle
    for (int c = 0; c < W; c++) timer[c] = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < W; c++) begin
        if (timer[c] == 0) begin
          btn[c] = 1'($urandom_range(0, 1));
          timer[c] = $urandom_range(1, 60);
        end else begin
          timer[c]--;
        end
      end
      if (t == 1500) rst = 1'b1;
      if (t == 1503) rst = 1'b0;
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_parser.md
Name: button_event_parser

Overview:
- Multi-channel button front end for the board top level; replaces the single-event debounce/edge path.
- Per channel: synchronises the raw pad input, debounces both press and release, and reports the debounced level.
- Emits one-cycle pulses for press, release and long-press events; the CPU and MMIO layer consume these directly.
- Sample timebase is shared across all channels; each channel has its own state machine.

Parameters:
- WIDTH, 4: number of button channels.
- SYNC_STAGES, 2: synchroniser flop depth; minimum 2.
- SAMPLE_CNT_MAX, 37500: clk cycles per sample tick (500 us at 75 MHz); minimum 1.
- PULSE_CNT_MAX, 200: consecutive equal samples needed to accept a press or release; minimum 1.
- LONG_CNT_MAX, 2000: consecutive high samples in HELD before long_press fires; minimum 1.
- REPEAT_CNT_MAX, 200: samples between auto-repeat pulses; used only with the optional feature.

Ports:
- clk  in  1  cpu_clk domain clock.
- rst  in  1  asynchronous, active-high reset.
- in  in  WIDTH  raw asynchronous button inputs, active-high.
- level  out  WIDTH  debounced button state.
- pressed  out  WIDTH  one-cycle pulse on accepted press (and on auto-repeat).
- released  out  WIDTH  one-cycle pulse on accepted release.
- long_press  out  WIDTH  one-cycle pulse when long-hold threshold is reached.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset state:
  - All synchroniser flops, the sample counter, and all per-channel counters and flags are 0; every state is IDLE.
  - level, pressed, released and long_press are all 0.
- Synchroniser: SYNC_STAGES flops per channel; s[i] is the last stage.
- Sample timebase:
  - Counter counts 0..SAMPLE_CNT_MAX-1 and wraps to 0.
  - tick is high for one cycle when count == SAMPLE_CNT_MAX-1.
  - The counter is free-running and starts at 0 after reset.
- Per-channel FSM: states IDLE, HELD, REL_DB. Each channel has counter cnt (sized for max(PULSE_CNT_MAX, LONG_CNT_MAX, REPEAT_CNT_MAX)) and a long_done flag. State changes only on tick.
- IDLE (level=0):
  - tick with s=1: cnt++.
  - tick with s=0: cnt=0.
  - When the tick produces the PULSE_CNT_MAX-th consecutive high sample: go to HELD, cnt=0, long_done=0, level<=1, pressed pulses.
- HELD (level=1):
  - tick with s=1 and long_done=0: cnt++. At LONG_CNT_MAX: long_press pulses, long_done=1, cnt=0.
  - tick with s=0: go to REL_DB with cnt=1. If PULSE_CNT_MAX==1, go straight to IDLE instead, with released pulse and level<=0.
- REL_DB (level stays 1):
  - tick with s=0: cnt++. At PULSE_CNT_MAX: go to IDLE, cnt=0, level<=0, released pulses.
  - tick with s=1 (glitch): return to HELD with cnt=0; long_done is kept, so long_press never fires twice in one press.
- Output timing:
  - All outputs are registered.
  - Pulses assert in the clk cycle after the deciding tick and last exactly 1 cycle.
  - level changes in that same cycle.
- Latency: raw edge to pressed/released is at most SYNC_STAGES + SAMPLE_CNT_MAX*PULSE_CNT_MAX + 1 cycles.
- Channels are fully independent; any combination of channels may pulse in the same cycle.
- Reset mid-operation: immediate return to the reset state, with no pulses emitted. An input already high at reset release is debounced as a fresh press.
- Pulses on one channel are mutually exclusive: pressed, released and long_press never assert together.

Optional Feature:
- Macro: BUTTON_AUTOREPEAT_EN.
- When defined:
  - In HELD with long_done=1, cnt counts high ticks.
  - At REPEAT_CNT_MAX, pressed pulses and cnt=0.
  - The first repeat is REPEAT_CNT_MAX ticks after long_press.
  - A glitch back from REL_DB restarts the repeat count at 0.
- When undefined: pressed fires once per press, REPEAT_CNT_MAX is ignored, and no repeat logic is synthesised.

Test Plan:
(All scenarios use SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, LONG_CNT_MAX=8, REPEAT_CNT_MAX=2, SYNC_STAGES=2, WIDTH=4.)
- Clean press: in[0] 0->1 held → exactly one pressed[0] pulse within 16 cycles of the edge; level[0]=1 from the same cycle; no other outputs.
- Bounce reject: in[1] high for 6 cycles, then low → no pressed[1] pulse; level[1] stays 0; then hold high for 20 cycles → exactly one pressed[1].
- Long press and release: hold in[2] high → long_press[2] exactly 8 ticks (32 cycles) after pressed[2]. Drop in[2] → released[2] within 16 cycles; level[2]=0.
- Release glitch: while in[0] is HELD, drive it low for 5 cycles, then high → no released[0]; level[0] stays 1; no second pressed[0].
- Simultaneous channels: in[3:0]=4'b1111 on one edge → pressed=4'b1111 in a single cycle; release all → released=4'b1111 in a single cycle.
- Reset and repeat:
  - Assert rst mid-REL_DB → all outputs 0 asynchronously; no released pulse.
  - With BUTTON_AUTOREPEAT_EN defined, a held button gives pressed pulses every 8 cycles after long_press.
